// File: rtl/vip_frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: state encoding, pooled-dimension
// derivation and counter-width helper.
package vip_frame_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } sched_state_e;

   // Output dimension after the whole max-pool chain.
   function automatic int out_dim(input int dim, input int pool_shift);
      return dim >> pool_shift;
   endfunction

   // Bits needed to hold values 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Beat counter that wraps after BEATS accepted beats and flags the final beat
// of each frame with a same-cycle wrap pulse.
module frame_pixel_counter
   import vip_frame_scheduler_pkg::*;
#(
   parameter int BEATS = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       beat,
   output logic [cnt_w(BEATS)-1:0]    count,
   output logic                       wrap
);

   localparam int CW = cnt_w(BEATS);
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   assign wrap = beat & (count == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (beat) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/vip_frame_scheduler.sv
// Frame-level flow control in front of vip_top: gates input writes image by
// image, tracks images in flight through conv/pool and signals run completion.
module vip_frame_scheduler
   import vip_frame_scheduler_pkg::*;
#(
   parameter int WIDTH        = 224,
   parameter int HEIGHT       = 224,
   parameter int NUM_IMG      = 4,
   parameter int POOL_SHIFT   = 5,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    start,
   input  logic                                    src_wrreq,
   output logic                                    src_full,
   output logic                                    core_wrreq,
   input  logic                                    core_full,
   input  logic                                    core_rdreq,
   input  logic                                    core_empty,
   output logic [cnt_w(NUM_IMG+1)-1:0]             img_in_cnt,
   output logic [cnt_w(NUM_IMG+1)-1:0]             img_out_cnt,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    error,
   output sched_state_e                            state_dbg,
   output logic [cnt_w(MAX_INFLIGHT+1)-1:0]        inflight_dbg,
   output logic [cnt_w(WIDTH*HEIGHT)-1:0]          in_pix_dbg,
   output logic [cnt_w(out_dim(WIDTH, POOL_SHIFT)*out_dim(HEIGHT, POOL_SHIFT))-1:0] out_pix_dbg
);

   localparam int IW        = cnt_w(NUM_IMG + 1);
   localparam int FW        = cnt_w(MAX_INFLIGHT + 1);
   localparam int IN_BEATS  = WIDTH * HEIGHT;
   localparam int OUT_BEATS = out_dim(WIDTH, POOL_SHIFT) * out_dim(HEIGHT, POOL_SHIFT);
   localparam logic [IW-1:0] NUM_IMG_C  = IW'(NUM_IMG);
   localparam logic [FW-1:0] MAX_INFL_C = FW'(MAX_INFLIGHT);

   sched_state_e       state, state_nxt;
   logic [IW-1:0]      img_in_q, img_out_q;
   logic [FW-1:0]      inflight_q;
   logic               error_q;
   logic               launch, admit, wr_ok, pop, in_wrap, out_wrap;

   // Handshake: an input pixel moves on src_wrreq & ~src_full (seen downstream
   // as core_wrreq); an output beat is counted on core_rdreq & ~core_empty.
   assign launch     = start & ((state == S_IDLE) | (state == S_DONE));
   assign admit      = (state == S_RUN) & (img_in_q < NUM_IMG_C) & (inflight_q < MAX_INFL_C);
   assign wr_ok      = src_wrreq & ~core_full & admit;
   assign core_wrreq = wr_ok;
   assign src_full   = core_full | ~admit;
   assign pop        = core_rdreq & ~core_empty;

   frame_pixel_counter #(.BEATS(IN_BEATS)) u_in_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (launch),
      .beat  (wr_ok),
      .count (in_pix_dbg),
      .wrap  (in_wrap)
   );

   frame_pixel_counter #(.BEATS(OUT_BEATS)) u_out_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (launch),
      .beat  (pop),
      .count (out_pix_dbg),
      .wrap  (out_wrap)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // DONE is entered on the edge of the final output pop, so done follows it
   // by one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (img_in_q == NUM_IMG_C) state_nxt = S_DRAIN;
         S_DRAIN: if ((img_out_q == NUM_IMG_C) ||
                      (out_wrap && (img_out_q == NUM_IMG_C - 1'b1))) state_nxt = S_DONE;
         S_DONE:  if (start) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         img_in_q   <= '0;
         img_out_q  <= '0;
         inflight_q <= '0;
         error_q    <= 1'b0;
      end else if (launch) begin
         img_in_q   <= '0;
         img_out_q  <= '0;
         inflight_q <= '0;
         error_q    <= 1'b0;
      end else begin
         if (in_wrap && (img_in_q != NUM_IMG_C)) img_in_q <= img_in_q + 1'b1;
         if (out_wrap && (img_out_q != NUM_IMG_C)) img_out_q <= img_out_q + 1'b1;
         // Simultaneous frame-in and frame-out completions cancel out.
         case ({in_wrap, out_wrap})
            2'b10:   inflight_q <= inflight_q + 1'b1;
            2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - 1'b1;
            default: inflight_q <= inflight_q;
         endcase
         if (pop && (inflight_q == '0)) error_q <= 1'b1;
      end
   end

   assign img_in_cnt   = img_in_q;
   assign img_out_cnt  = img_out_q;
   assign busy         = (state == S_RUN) | (state == S_DRAIN);
   assign done         = (state == S_DONE);
   assign error        = error_q;
   assign state_dbg    = state;
   assign inflight_dbg = inflight_q;

endmodule

// File: tb/tb_vip_frame_scheduler.sv
// Self-checking bench for vip_frame_scheduler: directed steps plus random
// traffic compared every cycle against a count-based reference model.
module tb_vip_frame_scheduler;
   import vip_frame_scheduler_pkg::*;

   localparam int W = 4, H = 4, PS = 1, N = 3, MI = 1;
   localparam int IN_B = 16, OUT_B = 4;

   // clock/reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic start = 0, src_wrreq = 0, core_full = 0, core_rdreq = 0, core_empty = 1;
   logic src_full, core_wrreq, busy, done, error;
   logic [cnt_w(N+1)-1:0] img_in_cnt, img_out_cnt;
   sched_state_e state_dbg;
   logic [cnt_w(MI+1)-1:0] inflight_dbg;
   logic [cnt_w(IN_B)-1:0] in_pix_dbg;
   logic [cnt_w(OUT_B)-1:0] out_pix_dbg;

   logic start2 = 0, src_wrreq2 = 0, core_full2 = 0, core_rdreq2 = 0, core_empty2 = 1;
   logic src_full2, core_wrreq2, busy2, done2, error2;
   logic [cnt_w(N+1)-1:0] img_in_cnt2, img_out_cnt2;
   sched_state_e state_dbg2;
   logic [cnt_w(3)-1:0] inflight_dbg2;
   logic [cnt_w(IN_B)-1:0] in_pix_dbg2;
   logic [cnt_w(OUT_B)-1:0] out_pix_dbg2;

   vip_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_IMG(N), .POOL_SHIFT(PS), .MAX_INFLIGHT(MI)) u_dut (
      .clock(clock), .reset(reset), .start(start), .src_wrreq(src_wrreq), .src_full(src_full),
      .core_wrreq(core_wrreq), .core_full(core_full), .core_rdreq(core_rdreq), .core_empty(core_empty),
      .img_in_cnt(img_in_cnt), .img_out_cnt(img_out_cnt), .busy(busy), .done(done), .error(error),
      .state_dbg(state_dbg), .inflight_dbg(inflight_dbg), .in_pix_dbg(in_pix_dbg), .out_pix_dbg(out_pix_dbg)
   );

   vip_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_IMG(N), .POOL_SHIFT(PS), .MAX_INFLIGHT(2)) u_dut2 (
      .clock(clock), .reset(reset), .start(start2), .src_wrreq(src_wrreq2), .src_full(src_full2),
      .core_wrreq(core_wrreq2), .core_full(core_full2), .core_rdreq(core_rdreq2), .core_empty(core_empty2),
      .img_in_cnt(img_in_cnt2), .img_out_cnt(img_out_cnt2), .busy(busy2), .done(done2), .error(error2),
      .state_dbg(state_dbg2), .inflight_dbg(inflight_dbg2), .in_pix_dbg(in_pix_dbg2), .out_pix_dbg(out_pix_dbg2)
   );

   int n_cmp = 0, n_err = 0;
   int n_wr = 0, n_pop = 0, n2 = 0;
   logic obs_wr;

   // reference model: image/pixel bookkeeping in plain integers
   int m_in_pix, m_out_pix, m_img_in, m_img_out, m_inflight;
   bit m_started, m_done, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_in_pix = 0; m_out_pix = 0; m_img_in = 0; m_img_out = 0; m_inflight = 0;
      m_started = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step(input bit st, input bit wok, input bit pop);
      bit iw, ow;
      if (st && (!m_started || m_done)) begin
         model_reset();
         m_started = 1;
         return;
      end
      iw = 0; ow = 0;
      if (pop && m_inflight == 0) m_err = 1;
      if (wok) begin
         if (m_in_pix == IN_B - 1) begin m_in_pix = 0; iw = 1; end
         else m_in_pix++;
      end
      if (pop) begin
         if (m_out_pix == OUT_B - 1) begin m_out_pix = 0; ow = 1; end
         else m_out_pix++;
      end
      if (iw && m_img_in < N) m_img_in++;
      if (ow && m_img_out < N) m_img_out++;
      if (iw && !ow) m_inflight++;
      else if (ow && !iw && m_inflight > 0) m_inflight--;
      if (m_started && !m_done && m_img_in == N && ow && m_img_out == N) m_done = 1;
   endtask

   // driver: one clock cycle on the MAX_INFLIGHT=1 instance, checked against the model
   task automatic cyc(input bit st, input bit wr, input bit full, input bit rd, input bit emp);
      bit exp_admit;
      start = st; src_wrreq = wr; core_full = full; core_rdreq = rd; core_empty = emp;
      #1;
      exp_admit = m_started && (m_img_in < N) && (m_inflight < MI);
      chk("core_wrreq", 32'(core_wrreq), 32'(wr && !full && exp_admit));
      chk("src_full", 32'(src_full), 32'(full || !exp_admit));
      chk("img_in_cnt", 32'(img_in_cnt), m_img_in);
      chk("img_out_cnt", 32'(img_out_cnt), m_img_out);
      chk("busy", 32'(busy), 32'(m_started && !m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      obs_wr = core_wrreq;
      if (core_wrreq === 1'b1) n_wr++;
      if (rd && !emp) n_pop++;
      model_step(st, wr && !full && exp_admit, rd && !emp);
      @(posedge clock);
      #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_src_full", 32'(src_full), 1);
      chk("rst_core_wrreq", 32'(core_wrreq), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_img_in", 32'(img_in_cnt), 0);
      chk("rst_img_out", 32'(img_out_cnt), 0);
      reset = 1'b0;

      // writes without start stay blocked
      repeat (4) cyc(0, 1, 0, 0, 1);

      // first frame: continuous writes, output empty
      n_wr = 0; n_pop = 0;
      cyc(1, 1, 0, 0, 1);
      repeat (20) cyc(0, 1, 0, 0, 1);
      chk("frame1_writes", n_wr, 16);
      chk("frame1_img_in", 32'(img_in_cnt), 1);
      chk("frame1_src_full", 32'(src_full), 1);

      // drain one pooled frame, writes resume next cycle
      repeat (4) cyc(0, 1, 0, 1, 0);
      chk("after_pops_img_out", 32'(img_out_cnt), 1);
      cyc(0, 1, 0, 0, 1);
      chk("writes_resume", 32'(obs_wr), 1);

      // random traffic to completion
      for (int i = 0; i < 3000 && !m_done; i++) begin
         bit e;
         e = (m_inflight == 0) ? 1'b1 : ($urandom_range(0, 1) == 0);
         cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, e);
      end
      chk("run_done", 32'(done), 1);
      chk("total_writes", n_wr, 48);
      chk("total_pops", n_pop, 12);

      // pop with nothing admitted -> sticky error, cleared by start
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      chk("error_sticky", 32'(error), 1);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      chk("error_cleared", 32'(error), 0);

      // core_full pulse inside frame 1; a start while running is ignored
      n_wr = 0;
      for (int i = 0; i < 25; i++) cyc(i == 10, 1, (i >= 3 && i < 7), 0, 1);
      chk("full_frame_writes", n_wr, 16);
      chk("full_frame_img_in", 32'(img_in_cnt), 1);

      // reset in the middle of a frame
      repeat (4) cyc(0, 1, 0, 1, 0);
      repeat (7) cyc(0, 1, 0, 0, 1);
      chk("in_pix_before_reset", 32'(in_pix_dbg), 7);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_src_full", 32'(src_full), 1);
      chk("arst_core_wrreq", 32'(core_wrreq), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_img_in", 32'(img_in_cnt), 0);
      chk("arst_img_out", 32'(img_out_cnt), 0);
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc(1, 1, 0, 0, 1);
      repeat (15) cyc(0, 1, 0, 0, 1);
      chk("img_in_after15", 32'(img_in_cnt), 0);
      cyc(0, 1, 0, 0, 1);
      chk("img_in_after16", 32'(img_in_cnt), 1);

      // MAX_INFLIGHT=2: frame-2 last write coincides with frame-1 last pop
      start2 = 1'b1;
      @(posedge clock);
      #1;
      start2 = 1'b0;
      n2 = 0;
      for (int k = 1; k <= 33; k++) begin
         src_wrreq2  = 1'b1;
         core_rdreq2 = (k >= 29 && k <= 32);
         core_empty2 = !(k >= 29 && k <= 32);
         #1;
         if (core_wrreq2 === 1'b1) n2++;
         if (k == 32) chk("dual_last_wrreq", 32'(core_wrreq2), 1);
         if (k == 33) begin
            chk("dual_inflight", 32'(inflight_dbg2), 1);
            chk("dual_img_in", 32'(img_in_cnt2), 2);
            chk("dual_img_out", 32'(img_out_cnt2), 1);
            chk("dual_continue", 32'(core_wrreq2), 1);
            chk("dual_error", 32'(error2), 0);
         end
         @(posedge clock);
         #1;
      end
      chk("dual_writes", n2, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vip_frame_scheduler.md
# vip_frame_scheduler

Frame-level flow controller between the multi-channel input generator/FIFO writer and `vip_top`. It gates input FIFO writes image by image, counts input pixels (`WIDTH*HEIGHT` per image) and pooled output pixels (`(WIDTH>>POOL_SHIFT)*(HEIGHT>>POOL_SHIFT)` per image), and limits the number of images in flight inside the conv/pool pipeline. It raises `done` once `NUM_IMG` classified images have left the output FIFO. The channel data buses bypass this block; only handshakes pass through it.

## Interface
- `WIDTH`, 224, input image width in pixels
- `HEIGHT`, 224, input image height in pixels
- `NUM_IMG`, 4, images per run (≥1)
- `POOL_SHIFT`, 5, total max-pool downscale as log2 (output dim = dim>>POOL_SHIFT, ≥1)
- `MAX_INFLIGHT`, 2, max images admitted but not fully drained (≥1)
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: one-cycle run request; honoured only in IDLE or DONE
- `src_wrreq` in 1: write request from the input generator
- `src_full` out 1: back-pressure to the generator
- `core_wrreq` out 1: gated write into `vip_top` input FIFOs
- `core_full` in 1: `vip_top` input FIFO full
- `core_rdreq` in 1: writer's read request on the `vip_top` output FIFO (monitored only)
- `core_empty` in 1: `vip_top` output FIFO empty (monitored only)
- `img_in_cnt` out clog2(NUM_IMG+1): images completely written
- `img_out_cnt` out clog2(NUM_IMG+1): images completely read out
- `busy` out 1: state is RUN or DRAIN
- `done` out 1: state is DONE
- `error` out 1: sticky protocol error

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + `start` → RUN. On this transition, clear all counters, `inflight`, and `error`.
- `admit` = (RUN) & (`img_in_cnt` < NUM_IMG) & (`inflight` < MAX_INFLIGHT).
- `wr_ok` = `src_wrreq` & ~`core_full` & `admit`. `core_wrreq` = `wr_ok`. `src_full` = `core_full` | ~`admit`. Both are combinational.
- Input side: `in_pix` increments on `wr_ok`. At WIDTH*HEIGHT-1 it wraps to 0, and `img_in_cnt` and `inflight` each increment.
- Output side: `pop` = `core_rdreq` & ~`core_empty`. `out_pix` increments on `pop`. At OUT_W*OUT_H-1 it wraps to 0, `img_out_cnt` increments, and `inflight` decrements.
- Same-cycle input-frame completion and output-frame completion: `inflight` is unchanged.
- RUN → DRAIN on the cycle `img_in_cnt` reaches NUM_IMG (registered compare).
- DRAIN → DONE when `img_out_cnt` reaches NUM_IMG.
- `error` is set on `pop` while `inflight`==0 (output with no admitted frame). Counters still advance in this case; `inflight` saturates at 0. `error` is cleared only by `start` or `reset`.
- `start` in RUN/DRAIN is ignored.
- Counters never exceed NUM_IMG. Writes are blocked once `img_in_cnt`==NUM_IMG.
- `reset` mid-frame: everything returns to IDLE/zero immediately. Partial frames are discarded from the count; the FIFOs are not this block's responsibility.

## Timing
- Reset values: `src_full`=1, `core_wrreq`=0, `busy`=0, `done`=0, `error`=0, `img_in_cnt`=`img_out_cnt`=0.
- Write path has zero latency: `core_wrreq` follows `src_wrreq` in the same cycle when admitted.
- Admission throttle takes effect on the cycle after the last pixel of a frame is accepted, because `inflight` is registered. Throughput is 1 pixel/cycle otherwise.
- `busy` and `done` are registered state decodes. `done` rises 1 cycle after the final output pop and holds until `start`.
- `start` in IDLE: `admit` becomes true the following cycle.

## Structure
- Shared package/header (alongside `dimension.v`):
  - scheduler state encoding
  - OUT_W/OUT_H derivation macro (`dim>>POOL_SHIFT`)
  - counter-width helper based on clog2
- One natural sub-module: `frame_pixel_counter`, a parameterised beat/frame counter with a wrap pulse. It is instantiated twice, once for the input side and once for the output side.
- FSM and `inflight` up/down counter stay in the top module.

## Test plan
All scenarios use WIDTH=4, HEIGHT=4, POOL_SHIFT=1 (4 output beats/img), NUM_IMG=3, MAX_INFLIGHT=1.
- Reset, then hold `src_wrreq`=1 with no `start` → `src_full`=1, `core_wrreq`=0, all counters 0.
- `start`, continuous writes, output FIFO empty → exactly 16 `core_wrreq` beats, then `src_full`=1, `img_in_cnt`=1.
- Then 4 pops → `img_out_cnt`=1 and writes resume on the next cycle. Full run ends with 48 writes, 12 pops, and `done`=1 one cycle after the 12th pop.
- With MAX_INFLIGHT=2: frame-2 last write and frame-1 last pop in the same cycle → `inflight` stays 1 and writing continues.
- Pulse `core_full` during frame 1 → `core_wrreq`=0 while it is asserted; the pixel count stays at exactly 16.
- A pop with no frame admitted → `error`=1 sticky. A subsequent `start` clears it.
- Assert `reset` at `in_pix`=7 → outputs return to reset values asynchronously. After restart, the first frame needs 16 full writes.
